ucsbece154b_gshare_predictor: RTL and testbench

Gshare direction predictor plus direct-mapped, tagged branch target buffer. It answers the fetch stage's per-PC prediction query and accepts resolved-outcome updates from the execute stage. It sits beside the pipelined datapath's PC mux:
- Fetch side: supplies the taken/not-taken decision, the target and the PHT index.
- Execute side: the datapath pipelines the PHT index to EX and returns the resolved outcome, which trains the PHT, the GHR and the BTB.

---
 rtl/ucsbece154b_gshare_predictor.sv | 104 ++++++++++
 tb/tb_ucsbece154b_gshare_predictor.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154b_gshare_predictor.sv
// Gshare direction predictor with a direct-mapped, tagged branch target buffer.
//
// Fetch side (combinational, zero latency):
//   pc_i              fetch PC being predicted
//   BranchTaken_o     redirect fetch to BTBtarget_o
//   BTBtarget_o       predicted target, 0 on BTB miss
//   PHTreadaddress_o  PHT index used for this prediction (pc bits XOR history)
// Execute side (sampled on posedge clk):
//   BTBwe_i, BTBwritepc_i, BTBwritedata_i, BTBwritejump_i   BTB fill/overwrite
//   PHTwe_i, PHTwriteaddress_i, PHTincrement_i               PHT + history training
//   GHRreset_i                                               clear history (wins over PHTwe_i)
// Clocking: clk, synchronous active-high reset.
module ucsbece154b_gshare_predictor #(
   parameter int unsigned NUM_BTB_ENTRIES = 32,
   parameter int unsigned NUM_GHR_BITS    = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [31:0]             pc_i,
   output logic                    BranchTaken_o,
   output logic [31:0]             BTBtarget_o,
   output logic [NUM_GHR_BITS-1:0] PHTreadaddress_o,
   input  logic                    BTBwe_i,
   input  logic [31:0]             BTBwritepc_i,
   input  logic [31:0]             BTBwritedata_i,
   input  logic                    BTBwritejump_i,
   input  logic                    PHTwe_i,
   input  logic [NUM_GHR_BITS-1:0] PHTwriteaddress_i,
   input  logic                    PHTincrement_i,
   input  logic                    GHRreset_i
);

   localparam int unsigned Idx        = $clog2(NUM_BTB_ENTRIES);
   localparam int unsigned TagW       = 30 - Idx;
   localparam int unsigned PhtEntries = 1 << NUM_GHR_BITS;

   logic [NUM_BTB_ENTRIES-1:0] btb_valid_q;
   logic [NUM_BTB_ENTRIES-1:0] btb_jump_q;
   logic [TagW-1:0]            btb_tag_q    [NUM_BTB_ENTRIES];
   logic [31:0]                btb_target_q [NUM_BTB_ENTRIES];
   logic [1:0]                 pht_q        [PhtEntries];
   logic [NUM_GHR_BITS-1:0]    ghr_q, ghr_d;
   logic [1:0]                 pht_cnt, pht_cnt_d;

   logic [Idx-1:0]  rd_idx, wr_idx;
   logic [TagW-1:0] rd_tag, wr_tag;
   logic            btb_hit;

   // Byte-offset bits never participate in indexing or tagging.
   logic unused_pc_lsbs;
   assign unused_pc_lsbs = ^{pc_i[1:0], BTBwritepc_i[1:0]};

   assign rd_idx = pc_i[Idx+1:2];
   assign rd_tag = pc_i[31:Idx+2];
   assign wr_idx = BTBwritepc_i[Idx+1:2];
   assign wr_tag = BTBwritepc_i[31:Idx+2];

   // Lookup: purely combinational on current state, so a same-cycle write is not bypassed.
   always_comb begin
      PHTreadaddress_o = pc_i[NUM_GHR_BITS+1:2] ^ ghr_q;
      btb_hit          = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == rd_tag);
      BranchTaken_o    = btb_hit && (btb_jump_q[rd_idx] || pht_q[PHTreadaddress_o][1]);
      BTBtarget_o      = btb_hit ? btb_target_q[rd_idx] : 32'b0;
   end

   // Saturating 2-bit counter step for the trained PHT entry.
   always_comb begin
      pht_cnt   = pht_q[PHTwriteaddress_i];
      pht_cnt_d = pht_cnt;
      if (PHTincrement_i) begin
         if (pht_cnt != 2'b11) pht_cnt_d = pht_cnt + 2'b01;
      end else begin
         if (pht_cnt != 2'b00) pht_cnt_d = pht_cnt - 2'b01;
      end
   end

   // History only advances on resolution; a mispredict clear takes priority.
   always_comb begin
      ghr_d = ghr_q;
      if (GHRreset_i) begin
         ghr_d = '0;
      end else if (PHTwe_i) begin
         ghr_d = {ghr_q[NUM_GHR_BITS-2:0], PHTincrement_i};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         btb_valid_q <= '0;
         for (int i = 0; i < PhtEntries; i++) pht_q[i] <= 2'b01;
         ghr_q <= '0;
      end else begin
         if (BTBwe_i) begin
            btb_valid_q[wr_idx]  <= 1'b1;
            btb_jump_q[wr_idx]   <= BTBwritejump_i;
            btb_tag_q[wr_idx]    <= wr_tag;
            btb_target_q[wr_idx] <= BTBwritedata_i;
         end
         if (PHTwe_i) pht_q[PHTwriteaddress_i] <= pht_cnt_d;
         ghr_q <= ghr_d;
      end
   end

endmodule

// File: tb/tb_ucsbece154b_gshare_predictor.sv
module tb_ucsbece154b_gshare_predictor;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_i;
   logic        BranchTaken_o;
   logic [31:0] BTBtarget_o;
   logic [4:0]  PHTreadaddress_o;
   logic        BTBwe_i;
   logic [31:0] BTBwritepc_i;
   logic [31:0] BTBwritedata_i;
   logic        BTBwritejump_i;
   logic        PHTwe_i;
   logic [4:0]  PHTwriteaddress_i;
   logic        PHTincrement_i;
   logic        GHRreset_i;

   int checks = 0;
   int errors = 0;

   ucsbece154b_gshare_predictor #(
      .NUM_BTB_ENTRIES(32),
      .NUM_GHR_BITS   (5)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .pc_i             (pc_i),
      .BranchTaken_o    (BranchTaken_o),
      .BTBtarget_o      (BTBtarget_o),
      .PHTreadaddress_o (PHTreadaddress_o),
      .BTBwe_i          (BTBwe_i),
      .BTBwritepc_i     (BTBwritepc_i),
      .BTBwritedata_i   (BTBwritedata_i),
      .BTBwritejump_i   (BTBwritejump_i),
      .PHTwe_i          (PHTwe_i),
      .PHTwriteaddress_i(PHTwriteaddress_i),
      .PHTincrement_i   (PHTincrement_i),
      .GHRreset_i       (GHRreset_i)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 1'b0; BTBwe_i = 1'b0; PHTwe_i = 1'b0; GHRreset_i = 1'b0;
   endtask

   task automatic btb_write(input logic [31:0] pc, input logic [31:0] tgt, input logic jmp);
      BTBwe_i = 1'b1; BTBwritepc_i = pc; BTBwritedata_i = tgt; BTBwritejump_i = jmp;
      tick();
      BTBwe_i = 1'b0;
   endtask

   task automatic pht_train(input logic [4:0] addr, input logic inc, input logic clr);
      PHTwe_i = 1'b1; PHTwriteaddress_i = addr; PHTincrement_i = inc; GHRreset_i = clr;
      tick();
      PHTwe_i = 1'b0; GHRreset_i = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      pc_i = 32'h10;
      #1;
      checks++;
      if (BranchTaken_o !== 1'b0) begin
         errors++; $display("FAIL reset_taken: got %0b want 0", BranchTaken_o);
      end
      checks++;
      if (BTBtarget_o !== 32'h0) begin
         errors++; $display("FAIL reset_target: got %h want 00000000", BTBtarget_o);
      end
      checks++;
      if (PHTreadaddress_o !== 5'h04) begin
         errors++; $display("FAIL reset_phtaddr: got %h want 04", PHTreadaddress_o);
      end
   endtask

   task automatic test_jump();
      btb_write(32'h20, 32'h100, 1'b1);
      pc_i = 32'h20; #1;
      checks++;
      if (BranchTaken_o !== 1'b1) begin
         errors++; $display("FAIL jump_taken: got %0b want 1", BranchTaken_o);
      end
      checks++;
      if (BTBtarget_o !== 32'h100) begin
         errors++; $display("FAIL jump_target: got %h want 00000100", BTBtarget_o);
      end
      checks++;
      if (PHTreadaddress_o !== 5'h08) begin
         errors++; $display("FAIL jump_phtaddr: got %h want 08", PHTreadaddress_o);
      end
      pc_i = 32'hA0; #1;
      checks++;
      if (BranchTaken_o !== 1'b0 || BTBtarget_o !== 32'h0) begin
         errors++;
         $display("FAIL tag_miss: got taken %0b target %h want 0 00000000",
                  BranchTaken_o, BTBtarget_o);
      end
   endtask

   // Back-to-back writes to the same index: the later write replaces the entry.
   task automatic test_back_to_back();
      btb_write(32'h20, 32'h111, 1'b1);
      btb_write(32'hA0, 32'h400, 1'b1);
      pc_i = 32'hA0; #1;
      checks++;
      if (BranchTaken_o !== 1'b1 || BTBtarget_o !== 32'h400) begin
         errors++;
         $display("FAIL overwrite_hit: got taken %0b target %h want 1 00000400",
                  BranchTaken_o, BTBtarget_o);
      end
      pc_i = 32'h20; #1;
      checks++;
      if (BranchTaken_o !== 1'b0 || BTBtarget_o !== 32'h0) begin
         errors++;
         $display("FAIL overwrite_old_miss: got taken %0b target %h want 0 00000000",
                  BranchTaken_o, BTBtarget_o);
      end
   endtask

   task automatic test_cond_branch();
      btb_write(32'h40, 32'h80, 1'b0);
      btb_write(32'h48, 32'hC0, 1'b0);
      pc_i = 32'h40; #1;
      checks++;
      if (BranchTaken_o !== 1'b0 || BTBtarget_o !== 32'h80 || PHTreadaddress_o !== 5'h10) begin
         errors++;
         $display("FAIL cond_first: got taken %0b target %h idx %h want 0 00000080 10",
                  BranchTaken_o, BTBtarget_o, PHTreadaddress_o);
      end
      pht_train(5'h10, 1'b1, 1'b0);
      pc_i = 32'h0; #1;
      checks++;
      if (PHTreadaddress_o !== 5'h01) begin
         errors++; $display("FAIL ghr_shift1: got %h want 01", PHTreadaddress_o);
      end
      pc_i = 32'h40; #1;
      checks++;
      if (PHTreadaddress_o !== 5'h11 || BranchTaken_o !== 1'b0) begin
         errors++;
         $display("FAIL cond_idx11: got idx %h taken %0b want 11 0",
                  PHTreadaddress_o, BranchTaken_o);
      end
      pht_train(5'h11, 1'b1, 1'b0);
      // GHR is now 00011, so pc 0x48 (bits 0x12) lands on the just-trained index 0x11.
      pc_i = 32'h48; #1;
      checks++;
      if (PHTreadaddress_o !== 5'h11 || BranchTaken_o !== 1'b1 || BTBtarget_o !== 32'hC0) begin
         errors++;
         $display("FAIL cond_trained: got idx %h taken %0b target %h want 11 1 000000c0",
                  PHTreadaddress_o, BranchTaken_o, BTBtarget_o);
      end
      pc_i = 32'h40; #1;
      checks++;
      if (PHTreadaddress_o !== 5'h13 || BranchTaken_o !== 1'b0) begin
         errors++;
         $display("FAIL cond_idx13: got idx %h taken %0b want 13 0",
                  PHTreadaddress_o, BranchTaken_o);
      end
   endtask

   task automatic test_saturation();
      logic exp_dec [4];
      exp_dec[0] = 1'b1; exp_dec[1] = 1'b0; exp_dec[2] = 1'b0; exp_dec[3] = 1'b0;
      btb_write(32'h60, 32'h200, 1'b0);
      // Each training also clears history so pc 0x60 keeps indexing 0x18.
      for (int i = 0; i < 6; i++) pht_train(5'h18, 1'b1, 1'b1);
      pc_i = 32'h60; #1;
      checks++;
      if (PHTreadaddress_o !== 5'h18 || BranchTaken_o !== 1'b1) begin
         errors++;
         $display("FAIL sat_high: got idx %h taken %0b want 18 1", PHTreadaddress_o, BranchTaken_o);
      end
      for (int i = 0; i < 4; i++) begin
         pht_train(5'h18, 1'b0, 1'b1);
         checks++;
         if (BranchTaken_o !== exp_dec[i]) begin
            errors++;
            $display("FAIL sat_dec%0d: got %0b want %0b", i + 1, BranchTaken_o, exp_dec[i]);
         end
      end
      // Held at 00: one increment reaches only 01.
      pht_train(5'h18, 1'b1, 1'b1);
      checks++;
      if (BranchTaken_o !== 1'b0) begin
         errors++; $display("FAIL sat_low_hold: got %0b want 0", BranchTaken_o);
      end
   endtask

   task automatic test_priority();
      logic [4:0] hist;
      hist = 5'b10110;
      for (int i = 4; i >= 0; i--) pht_train(5'h07, hist[i], 1'b0);
      pc_i = 32'h0; #1;
      checks++;
      if (PHTreadaddress_o !== 5'h16) begin
         errors++; $display("FAIL ghr_build: got %h want 16", PHTreadaddress_o);
      end
      pht_train(5'h18, 1'b1, 1'b1);
      checks++;
      if (PHTreadaddress_o !== 5'h00) begin
         errors++; $display("FAIL ghr_reset_prio: got %h want 00", PHTreadaddress_o);
      end
      pc_i = 32'h60; #1;
      checks++;
      if (BranchTaken_o !== 1'b1) begin
         errors++; $display("FAIL prio_pht_inc: got %0b want 1", BranchTaken_o);
      end
   endtask

   task automatic test_same_cycle();
      pc_i = 32'h1C;
      BTBwe_i = 1'b1; BTBwritepc_i = 32'h1C; BTBwritedata_i = 32'h300; BTBwritejump_i = 1'b1;
      #1;
      checks++;
      if (BranchTaken_o !== 1'b0 || BTBtarget_o !== 32'h0) begin
         errors++;
         $display("FAIL same_cycle_old: got taken %0b target %h want 0 00000000",
                  BranchTaken_o, BTBtarget_o);
      end
      tick();
      BTBwe_i = 1'b0;
      checks++;
      if (BranchTaken_o !== 1'b1 || BTBtarget_o !== 32'h300) begin
         errors++;
         $display("FAIL same_cycle_new: got taken %0b target %h want 1 00000300",
                  BranchTaken_o, BTBtarget_o);
      end
   endtask

   // Reset with every strobe high: all writes are discarded and state is cleared.
   task automatic test_reset_override();
      pht_train(5'h03, 1'b1, 1'b0);
      reset = 1'b1;
      BTBwe_i = 1'b1; BTBwritepc_i = 32'h2C; BTBwritedata_i = 32'h500; BTBwritejump_i = 1'b1;
      PHTwe_i = 1'b1; PHTwriteaddress_i = 5'h18; PHTincrement_i = 1'b1;
      tick();
      idle();
      pc_i = 32'h0; #1;
      checks++;
      if (PHTreadaddress_o !== 5'h00) begin
         errors++; $display("FAIL rst_ghr: got %h want 00", PHTreadaddress_o);
      end
      pc_i = 32'h2C; #1;
      checks++;
      if (BranchTaken_o !== 1'b0 || BTBtarget_o !== 32'h0) begin
         errors++;
         $display("FAIL rst_btb_write: got taken %0b target %h want 0 00000000",
                  BranchTaken_o, BTBtarget_o);
      end
      pc_i = 32'h1C; #1;
      checks++;
      if (BranchTaken_o !== 1'b0 || BTBtarget_o !== 32'h0) begin
         errors++;
         $display("FAIL rst_btb_valid: got taken %0b target %h want 0 00000000",
                  BranchTaken_o, BTBtarget_o);
      end
      // Counter at 0x18 was 10 before reset; after reset it must be 01 again.
      btb_write(32'h60, 32'h200, 1'b0);
      pc_i = 32'h60; #1;
      checks++;
      if (BranchTaken_o !== 1'b0 || BTBtarget_o !== 32'h200) begin
         errors++;
         $display("FAIL rst_pht: got taken %0b target %h want 0 00000200",
                  BranchTaken_o, BTBtarget_o);
      end
   endtask

   initial begin
      idle();
      pc_i = 32'h0; BTBwritepc_i = 32'h0; BTBwritedata_i = 32'h0; BTBwritejump_i = 1'b0;
      PHTwriteaddress_i = 5'h0; PHTincrement_i = 1'b0;
      test_reset();
      test_jump();
      test_back_to_back();
      test_cond_branch();
      test_saturation();
      test_priority();
      test_same_cycle();
      test_reset_override();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
